// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops an async-FIFO read port into a 2-entry valid/ready stream buffer
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [CNT_W-1:0] xfer_cnt
);
  typedef enum logic [1:0] {ZERO, ONE, TWO} state_t;
  state_t state_q, state_d;
  logic [DSIZE-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic acc;
  assign rinc = rrst_n && !rempty && (state_q != TWO);
  assign m_valid = state_q != ZERO;
  assign m_data = buf0_q;
  assign xfer_cnt = cnt_q;
  assign acc = m_valid && m_ready;
  // occupancy transitions; a popped word lands in the first free slot after any shift
  always_comb begin
    state_d = state_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d = cnt_q + CNT_W'(acc);
    case (state_q)
      ZERO: if (rinc) begin
        state_d = ONE;
        buf0_d = rdata;
      end
      ONE: if (rinc && acc) buf0_d = rdata;
      else if (rinc) begin
        state_d = TWO;
        buf1_d = rdata;
      end else if (acc) state_d = ZERO;
      TWO: if (acc) begin
        state_d = ONE;
        buf0_d = buf1_q;
      end
      default: state_d = ZERO;
    endcase
  end
  // state register with synchronous active-low reset
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q <= ZERO;
      buf0_q <= '0;
      buf1_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side consumer for the async FIFO, in the read clock domain. It pops words from the FIFO read port (combinational `rdata`, registered `rempty`, `rinc` pop strobe) and presents them as a valid/ready stream. A 2-entry output buffer keeps `rinc` independent of downstream `m_ready`, so there is no combinational path from `m_ready` to the FIFO pointer logic. It also keeps a wrapping count of delivered words for debug and verification.

## Interface
- `DSIZE`, default 8: data width; must match the FIFO `DSIZE`.
- `CNT_W`, default 16: width of the delivered-word counter.

Ports:
- `rclk`  input  1  read-domain clock. All state updates on its rising edge.
- `rrst_n`  input  1  reset: synchronous, active-low.
- `rempty`  input  1  FIFO empty flag. When low, `rdata` holds the oldest unread word.
- `rdata`  input  DSIZE  FIFO head word. Valid only while `rempty` is low.
- `rinc`  output  1  FIFO pop strobe. The FIFO advances on the `rclk` edge where `rinc` is high.
- `m_valid`  output  1  stream data valid.
- `m_ready`  input  1  downstream accept.
- `m_data`  output  DSIZE  stream data.
- `xfer_cnt`  output  CNT_W  number of accepted stream words (`m_valid && m_ready`), modulo 2^CNT_W.

## Operation
- Storage: two entries, `buf0` (head, always drives `m_data`) and `buf1`, plus occupancy state.
- State machine on occupancy:
  - ZERO → ONE on a pop.
  - ONE → TWO on a pop with no accept.
  - ONE → ZERO on an accept with no pop.
  - ONE → ONE on a simultaneous pop and accept; the new word loads into `buf0`.
  - TWO → ONE on an accept; `buf1` shifts into `buf0`.
- Pop rule: `rinc = rrst_n && !rempty && (state != TWO)`. `rinc` is never a function of `m_ready`.
- Pop capture: on a pop edge, `rdata` is written into the first free slot after any shift in the same cycle.
  - From ZERO, or from ONE with an accept: into `buf0`.
  - From ONE without an accept: into `buf1`.
- Outputs:
  - `m_valid = (state != ZERO)`.
  - `m_data = buf0`.
- Ordering: strict FIFO order. No word is duplicated or dropped.
- Hold rule: while `m_valid && !m_ready`, `m_data` and `m_valid` stay stable.
- Accept: `m_valid && m_ready` at an edge retires `buf0`.
- Counter: `xfer_cnt` increments by 1 per accept and wraps from 2^CNT_W-1 to 0. Arithmetic is unsigned, CNT_W bits.
- Register contents when invalid: `buf1` contents are don't-care when unoccupied. `buf0` holds its last value when state is ZERO.

## Timing
- Reset (`rrst_n` low at an edge):
  - State goes to ZERO; `buf0`, `buf1` and `xfer_cnt` go to 0.
  - After that edge, `m_valid` is 0 and `m_data` is 0.
  - `rinc` is forced to 0 combinationally for the whole time `rrst_n` is low.
- Reset mid-operation: buffered words are discarded. The block does not reset the FIFO; the system asserts both resets together.
- Latency: a word at the FIFO head with `rempty` low in cycle N, popped at edge N, appears on `m_data` with `m_valid` high in cycle N+1.
- Throughput: one word per cycle sustained when `rempty` stays low and `m_ready` stays high (steady state ONE).
- Backpressure: with `m_ready` low, at most two words are popped, then `rinc` drops.
  - After `m_ready` rises, the first accept edge moves TWO → ONE.
  - `rinc` reasserts in the following cycle.
- Empty FIFO: `rempty` high gives `rinc` 0; buffered words still drain to the stream.
- Simultaneous pop and accept in ONE: occupancy is unchanged and `xfer_cnt` increments.
- `rempty` is taken as registered and correct one cycle after a pop; no extra guard is required.

## Test plan
- Reset check: hold `rrst_n` low for 3 cycles with `rempty`=0 and `rdata`=0xA5.
  - During reset: `rinc`=0.
  - After the reset edge: `m_valid`=0, `m_data`=0, `xfer_cnt`=0.
- Streaming: FIFO holds 0x01..0x08, `m_ready` tied high.
  - `m_data` shows 0x01..0x08 on 8 consecutive cycles starting one cycle after the first `rinc`.
  - `xfer_cnt`=8, and `rinc` falls when `rempty` rises.
- Backpressure: FIFO holds 0x10..0x13 and `m_ready`=0 for 5 cycles.
  - Exactly 2 `rinc` pulses; `m_data`=0x10 stays stable.
  - After `m_ready`=1: output order is 0x10, 0x11, 0x12, 0x13 with no gaps after the first.
- Alternating `m_ready` (1,0,1,0…) with a full FIFO of 16 words:
  - All 16 words arrive in order.
  - `m_data` never changes while `m_valid && !m_ready`.
  - Final `xfer_cnt`=16.
- Counter wrap: `CNT_W`=4, stream 18 words → final `xfer_cnt`=2.
- Mid-stream reset: assert `rrst_n` low for 1 cycle while in state TWO.
  - Next cycle: `m_valid`=0, `xfer_cnt`=0.
  - Popping resumes only once `rrst_n` is high and `rempty` is low.
